// File: rtl/counter_mod_if.sv
// Control/data bundle for counter_mod: the master drives the controls and load data,
// the slave (the counter) returns its value and status.
interface counter_mod_if #(
  parameter int unsigned word_width = 8
);
  logic                  count;
  logic                  load;
  logic                  dir;
  logic                  sat;
  logic [word_width-1:0] limit;
  logic [word_width-1:0] D_IN;
  logic [word_width-1:0] D_OUT;
  logic                  wrap;
  logic                  at_limit;

  modport master (
    output count, load, dir, sat, limit, D_IN,
    input  D_OUT, wrap, at_limit
  );

  modport slave (
    input  count, load, dir, sat, limit, D_IN,
    output D_OUT, wrap, at_limit
  );
endinterface

// File: rtl/counter_mod.sv
// Loadable up/down modulo counter with wrap/saturate modes and a registered wrap pulse.
// Optional tick prescaler is enabled by defining COUNTER_MOD_PRESCALE_EN.
module counter_mod #(
  parameter int unsigned word_width   = 8,
  parameter int unsigned prescale_div = 4
) (
  input logic          clk,
  input logic          reset,
  counter_mod_if.slave bus
);

  logic [word_width-1:0] val_q;
  logic [word_width-1:0] val_next;
  logic                  wrap_q;
  logic                  wrap_next;
  logic                  tick;

`ifdef COUNTER_MOD_PRESCALE_EN
  localparam int unsigned PW = (prescale_div > 1) ? $clog2(prescale_div) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(prescale_div - 1);

  logic [PW-1:0] pre_q;

  // Prescaler advances only on counting cycles; its last phase is the tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else if (bus.load) begin
      pre_q <= '0;
    end else if (bus.count) begin
      pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end
  end

  assign tick = bus.count && !bus.load && (pre_q == PRE_LAST);
`else
  assign tick = bus.count && !bus.load;
`endif

  // Limit compare precedes the step, so no carry/borrow leaves word_width.
  always_comb begin
    val_next  = val_q;
    wrap_next = 1'b0;
    if (bus.load) begin
      val_next = (bus.D_IN > bus.limit) ? bus.limit : bus.D_IN;
    end else if (tick) begin
      if (!bus.dir) begin
        if (val_q < bus.limit) begin
          val_next = val_q + word_width'(1);
        end else if (!bus.sat) begin
          val_next  = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (val_q != '0) begin
          val_next = val_q - word_width'(1);
        end else if (!bus.sat) begin
          val_next  = bus.limit;
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      val_q  <= val_next;
      wrap_q <= wrap_next;
    end
  end

  assign bus.D_OUT    = val_q;
  assign bus.wrap     = wrap_q;
  assign bus.at_limit = bus.dir ? (val_q == '0) : (val_q >= bus.limit);

endmodule

// File: tb/tb_counter_mod.sv
// Directed scoreboard bench for counter_mod; the prescaler sequence runs when
// COUNTER_MOD_PRESCALE_EN is defined, the base sequence otherwise.
module tb_counter_mod;

`ifdef COUNTER_MOD_PRESCALE_EN
  localparam int unsigned PDIV = 4;
`else
  localparam int unsigned PDIV = 4;
`endif

  typedef struct {
    logic [7:0] val;
    logic       w;
    logic       al;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  counter_mod_if #(.word_width(8)) bus ();

  counter_mod #(
    .word_width  (8),
    .prescale_div(PDIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_now(input logic [7:0] v, input logic w, input logic d, input logic [7:0] lim);
    exp_t e;
    e.val = v;
    e.w   = w;
    e.al  = d ? (v == 8'd0) : (v >= lim);
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (bus.D_OUT === e.val) else begin
      failures++;
      $error("FAIL %s D_OUT observed=%0d expected=%0d", tag, bus.D_OUT, e.val);
    end
    checks++;
    assert (bus.wrap === e.w) else begin
      failures++;
      $error("FAIL %s wrap observed=%b expected=%b", tag, bus.wrap, e.w);
    end
    checks++;
    assert (bus.at_limit === e.al) else begin
      failures++;
      $error("FAIL %s at_limit observed=%b expected=%b", tag, bus.at_limit, e.al);
    end
  endtask

  // Drive one cycle of inputs at negedge, queue the expectation, check after the edge.
  task automatic step(input string tag, input logic c, input logic l, input logic d, input logic s,
                      input logic [7:0] lim, input logic [7:0] din,
                      input logic [7:0] exp_v, input logic exp_w);
    @(negedge clk);
    bus.count = c;
    bus.load  = l;
    bus.dir   = d;
    bus.sat   = s;
    bus.limit = lim;
    bus.D_IN  = din;
    expect_now(exp_v, exp_w, d, lim);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    reset     = 1'b0;
    bus.count = 1'b0;
    bus.load  = 1'b0;
    bus.dir   = 1'b0;
    bus.sat   = 1'b0;
    bus.limit = 8'd12;
    bus.D_IN  = 8'd0;
    #2;
    expect_now(8'd0, 1'b0, 1'b0, 8'd12);
    check_out("reset_state");
    @(negedge clk);
    reset = 1'b1;

`ifdef COUNTER_MOD_PRESCALE_EN
    step("pre_load0", 0, 1, 0, 0, 8'd15, 8'd0, 8'd0, 0);
    for (int unsigned i = 1; i <= 12; i++)
      step("pre_run", 1, 0, 0, 0, 8'd15, 8'd0, 8'(i / 4), 0);
    step("pre_load0b", 0, 1, 0, 0, 8'd15, 8'd0, 8'd0, 0);
    for (int unsigned i = 1; i <= 5; i++)
      step("pre_phase", 1, 0, 0, 0, 8'd15, 8'd0, 8'(i / 4), 0);
    step("pre_load_mid", 1, 1, 0, 0, 8'd15, 8'd1, 8'd1, 0);
    for (int unsigned i = 1; i <= 4; i++)
      step("pre_restart", 1, 0, 0, 0, 8'd15, 8'd0, (i == 4) ? 8'd2 : 8'd1, 0);
`else
    for (int unsigned i = 1; i <= 5; i++)
      step("count_up", 1, 0, 0, 0, 8'd12, 8'd0, 8'(i), 0);
    // Asynchronous reset with count still asserted
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    expect_now(8'd0, 1'b0, 1'b0, 8'd12);
    check_out("async_reset");
    @(posedge clk);
    #1;
    expect_now(8'd0, 1'b0, 1'b0, 8'd12);
    check_out("reset_hold");
    @(negedge clk);
    bus.count = 1'b0;
    reset     = 1'b1;
    step("load9", 0, 1, 0, 0, 8'd12, 8'd9, 8'd9, 0);

    step("upw_load0", 0, 1, 0, 0, 8'd3, 8'd0, 8'd0, 0);
    step("upw_1", 1, 0, 0, 0, 8'd3, 8'd0, 8'd1, 0);
    step("upw_2", 1, 0, 0, 0, 8'd3, 8'd0, 8'd2, 0);
    step("upw_3", 1, 0, 0, 0, 8'd3, 8'd0, 8'd3, 0);
    step("upw_wrap", 1, 0, 0, 0, 8'd3, 8'd0, 8'd0, 1);
    step("upw_after", 1, 0, 0, 0, 8'd3, 8'd0, 8'd1, 0);

    step("dnw_load1", 0, 1, 1, 0, 8'd3, 8'd1, 8'd1, 0);
    step("dnw_0", 1, 0, 1, 0, 8'd3, 8'd0, 8'd0, 0);
    step("dnw_wrap", 1, 0, 1, 0, 8'd3, 8'd0, 8'd3, 1);
    step("dnw_2", 1, 0, 1, 0, 8'd3, 8'd0, 8'd2, 0);

    step("dns_load1", 0, 1, 1, 1, 8'd3, 8'd1, 8'd1, 0);
    step("dns_0", 1, 0, 1, 1, 8'd3, 8'd0, 8'd0, 0);
    step("dns_hold1", 1, 0, 1, 1, 8'd3, 8'd0, 8'd0, 0);
    step("dns_hold2", 1, 0, 1, 1, 8'd3, 8'd0, 8'd0, 0);

    step("ups_load3", 0, 1, 0, 1, 8'd3, 8'd3, 8'd3, 0);
    step("ups_hold", 1, 0, 0, 1, 8'd3, 8'd0, 8'd3, 0);

    step("clamp", 1, 1, 0, 0, 8'd10, 8'd200, 8'd10, 0);
    step("load_over_wrap", 1, 1, 0, 0, 8'd10, 8'd5, 8'd5, 0);

    step("shrink_load8", 0, 1, 0, 0, 8'd12, 8'd8, 8'd8, 0);
    step("shrink_noclamp", 0, 0, 0, 0, 8'd4, 8'd0, 8'd8, 0);
    step("shrink_wrap", 1, 0, 0, 0, 8'd4, 8'd0, 8'd0, 1);
    step("shrink_load8b", 0, 1, 0, 0, 8'd12, 8'd8, 8'd8, 0);
    step("shrink_down", 1, 0, 1, 0, 8'd4, 8'd0, 8'd7, 0);

    step("full_load", 0, 1, 0, 0, 8'd255, 8'd255, 8'd255, 0);
    step("full_wrap", 1, 0, 0, 0, 8'd255, 8'd0, 8'd0, 1);
    step("full_1", 1, 0, 0, 0, 8'd255, 8'd0, 8'd1, 0);

    step("lim0_load", 0, 1, 0, 0, 8'd0, 8'd7, 8'd0, 0);
    step("lim0_wrap1", 1, 0, 0, 0, 8'd0, 8'd0, 8'd0, 1);
    step("lim0_wrap2", 1, 0, 0, 0, 8'd0, 8'd0, 8'd0, 1);
    step("lim0_sat", 1, 0, 0, 1, 8'd0, 8'd0, 8'd0, 0);
    step("lim0_dn_wrap", 1, 0, 1, 0, 8'd0, 8'd0, 8'd0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_mod.md
Name: counter_mod

Overview:
- Parametrised loadable up/down counter with a programmable modulus (limit), selectable wrap or saturate mode, and a registered wrap pulse.
- Next generation of the counter_c loadable counter.
- Used for address sequencing, loop counting and timebase generation in the datapath and control units.
- Drives no gated clock: all state runs on clk, qualified by enables.

Parameters:
- word_width, 8, counter/limit/data width in bits (>= 2).
- prescale_div, 4, prescaler division ratio used only when COUNTER_MOD_PRESCALE_EN is defined (>= 1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears state immediately, independent of clk.
- count  input  1  count enable; one step per enabled tick.
- load  input  1  synchronous load of D_IN.
- dir  input  1  direction: 0 = up, 1 = down.
- sat  input  1  boundary mode: 0 = wrap, 1 = saturate.
- limit  input  word_width  modulus top value; legal count range is 0..limit inclusive.
- D_IN  input  word_width  load data.
- D_OUT  output  word_width  registered counter value.
- wrap  output  1  registered one-cycle pulse: a wrap occurred on the previous edge.
- at_limit  output  1  combinational terminal flag: (dir==0 && D_OUT>=limit) || (dir==1 && D_OUT==0).

Behaviour:
- Reset (reset==0, async): D_OUT=0, wrap=0, prescaler=0. Outputs hold these values until the first rising clk edge after reset returns to 1.
- Priority per edge: load > count > hold.
- Load (load==1): D_OUT <= (D_IN > limit) ? limit : D_IN.
  - count is ignored that cycle.
  - wrap <= 0.
  - Prescaler cleared.
- Enabled tick is count==1 && load==0 (when prescaled, see Optional Feature).
- Up step (dir==0):
  - If D_OUT < limit: D_OUT+1.
  - Else if sat==0: D_OUT <= 0 and wrap <= 1.
  - Else: hold.
- Down step (dir==1):
  - If D_OUT != 0: D_OUT-1.
  - Else if sat==0: D_OUT <= limit and wrap <= 1.
  - Else: hold.
- wrap is 0 on every edge that does not wrap. It is never high for two consecutive cycles unless successive edges both wrap (e.g. limit==0 in wrap mode).
- Comparisons and arithmetic are unsigned, word_width wide. No carry out of word_width is ever produced, because the limit compare precedes the increment.
- limit == 2^word_width-1: full-range counter; up wraps from all-ones to 0.
- limit == 0: D_OUT stays 0.
  - Wrap mode: every enabled tick pulses wrap.
  - Saturate mode: no wrap pulse.
- limit changed below the current D_OUT:
  - Up: next enabled tick treats D_OUT as at/over limit (wrap to 0 or hold).
  - Down: decrements normally toward 0.
  - No implicit clamp without a tick.
- dir or sat changes take effect on the next enabled tick. No pipeline; latency from inputs to D_OUT is one edge.
- Reset asserted mid-count aborts immediately. No partial update or wrap pulse survives reset.

Optional Feature:
- Macro: COUNTER_MOD_PRESCALE_EN.
- Defined:
  - An internal prescaler of width clog2(prescale_div) increments on every cycle with count==1 && load==0.
  - An enabled tick occurs only when the prescaler equals prescale_div-1; the prescaler then returns to 0.
  - The prescaler is cleared by reset and load.
  - The prescaler holds when count==0.
  - prescale_div==1 behaves identically to the undefined case.
- Undefined: no prescaler logic. Every cycle with count==1 && load==0 is an enabled tick.

Test Plan:
- Reset/load: hold reset=0 mid-count at D_OUT=5, then release. Expect D_OUT=0 and wrap=0 asynchronously. Then load=1, D_IN=9, limit=12 -> D_OUT=9 next edge.
- Up wrap: limit=3, sat=0, dir=0, count=1 from 0 -> D_OUT 1,2,3,0,1. wrap high exactly the cycle after 3->0. at_limit high while D_OUT=3.
- Down wrap/saturate: limit=3, dir=1, from 1.
  - sat=0 -> 0, 3, 2; one wrap pulse.
  - sat=1 -> 0, 0, 0; no wrap pulse.
- Load clamp and priority: limit=10, load=1, count=1, D_IN=200 -> D_OUT=10, wrap=0, no step.
- Limit shrink / full range:
  - D_OUT=8, set limit=4, up, wrap mode -> next tick D_OUT=0 with wrap pulse.
  - word_width=8, limit=255, D_OUT=255, up -> D_OUT=0, wrap=1.
- Prescale (macro defined, prescale_div=4): count=1 for 12 cycles from 0, limit=15 -> D_OUT reaches 3. A load at cycle 6 restarts the 4-cycle prescaler phase.
